// File: rtl/spart_echo_ctrl.sv
// spart_echo_ctrl: bus master for the spart UART. Programs the baud divisor,
// then echoes received bytes back out through a small FIFO. Optional macro
// CASE_FLIP_EN swaps ASCII letter case on bytes entering the FIFO.
// Latency: one bus access per 3 cycles minimum (IDLE -> access -> GAP).
// Backpressure: when the FIFO is full, rda is left pending; spart holds the byte.

// spart_echo_fifo: circular echo buffer, pointers wrap modulo DEPTH.
// Latency: pushed data is visible at the head on the cycle after the push.
// Backpressure: a push when full or a pop when empty is ignored; the caller gates on full/empty.
module spart_echo_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             push_dat,
   output logic [W-1:0]             head_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   cnt_q;

   logic do_push;
   logic do_pop;

   assign full     = (cnt_q == (AW+1)'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign head_dat = mem_q[rd_ptr_q];
   assign level    = cnt_q;

   // Storage array: no reset needed, contents are only read when cnt_q says valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_dat;
      end
   end

   // Pointers and occupancy; DEPTH is a power of two so pointer overflow is the wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

module spart_echo_ctrl #(
   parameter int CLK_HZ     = 50000000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [1:0]                    br_cfg,
   input  logic                          rda,
   input  logic                          tbr,
   output logic                          iocs,
   output logic                          iorw,
   output logic [1:0]                    ioaddr,
   inout  wire  [7:0]                    databus,
   output logic                          cfg_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   localparam logic [1:0] ADDR_DATA   = 2'b00;
   localparam logic [1:0] ADDR_DIV_LO = 2'b10;
   localparam logic [1:0] ADDR_DIV_HI = 2'b11;

   function automatic logic [15:0] div_calc(input int baud);
      return 16'((CLK_HZ / (16 * baud)) - 1);
   endfunction

   localparam logic [15:0] DIV_4800  = div_calc(4800);
   localparam logic [15:0] DIV_9600  = div_calc(9600);
   localparam logic [15:0] DIV_19200 = div_calc(19200);
   localparam logic [15:0] DIV_38400 = div_calc(38400);

   typedef enum logic [2:0] {
      S_CFG_LO,
      S_CFG_HI,
      S_IDLE,
      S_RD,
      S_WR,
      S_GAP
   } state_t;

   typedef enum logic {
      SIDE_RD,
      SIDE_WR
   } side_t;

   state_t        state_q;
   state_t        state_d;
   side_t         rr_last_q;
   logic          run_q;
   logic [1:0]    cfg_q;
   logic          cfg_done_q;

   logic          latch_cfg;
   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_head;
   logic [7:0]    push_dat;
   logic [LW-1:0] level;
   logic          rd_req;
   logic          wr_req;
   logic [15:0]   div_sel;
   logic [7:0]    dout;
   logic          bus_drive;

   // Divisor for the latched baud selection.
   always_comb begin
      div_sel = DIV_9600;
      case (cfg_q)
         2'b00:   div_sel = DIV_4800;
         2'b01:   div_sel = DIV_9600;
         2'b10:   div_sel = DIV_19200;
         default: div_sel = DIV_38400;
      endcase
   end

`ifdef CASE_FLIP_EN
   // Letters have bit 5 inverted on the way in, so 'A' echoes as 'a' and vice versa.
   always_comb begin
      push_dat = databus;
      if ((databus >= 8'h41 && databus <= 8'h5A) ||
          (databus >= 8'h61 && databus <= 8'h7A)) begin
         push_dat[5] = ~databus[5];
      end
   end
`else
   assign push_dat = databus;
`endif

   spart_echo_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (8)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push),
      .pop      (fifo_pop),
      .push_dat (push_dat),
      .head_dat (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (level)
   );

   assign fifo_level = level;
   assign rd_req     = rda && !fifo_full;
   assign wr_req     = tbr && !fifo_empty;

   // Next state, FIFO strobes and cfg latch request; a baud change pre-empts all traffic.
   always_comb begin
      state_d   = state_q;
      latch_cfg = 1'b0;
      fifo_push = 1'b0;
      fifo_pop  = 1'b0;
      case (state_q)
         S_CFG_LO: begin
            // Held here for the first cycle after reset until run_q is set.
            if (run_q) begin
               state_d = S_CFG_HI;
            end
         end
         S_CFG_HI: state_d = S_GAP;
         S_IDLE: begin
            if (br_cfg != cfg_q) begin
               latch_cfg = 1'b1;
               state_d   = S_CFG_LO;
            end else if (rd_req && wr_req) begin
               state_d = (rr_last_q == SIDE_RD) ? S_WR : S_RD;
            end else if (rd_req) begin
               state_d = S_RD;
            end else if (wr_req) begin
               state_d = S_WR;
            end
         end
         S_RD: begin
            fifo_push = 1'b1;
            state_d   = S_GAP;
         end
         S_WR: begin
            fifo_pop = 1'b1;
            state_d  = S_GAP;
         end
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_CFG_LO;
      endcase
   end

   // State, arbitration history, latched baud selection and configuration status.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_CFG_LO;
         rr_last_q  <= SIDE_WR;
         run_q      <= 1'b0;
         cfg_q      <= br_cfg;
         cfg_done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
         if (latch_cfg) begin
            cfg_q      <= br_cfg;
            cfg_done_q <= 1'b0;
         end
         if (state_q == S_CFG_HI) begin
            cfg_done_q <= 1'b1;
         end
         if (fifo_push) begin
            rr_last_q <= SIDE_RD;
         end
         if (fifo_pop) begin
            rr_last_q <= SIDE_WR;
         end
      end
   end

   // Bus strobes decoded from registered state; run_q keeps the bus quiet while in reset.
   always_comb begin
      iocs   = 1'b0;
      iorw   = 1'b1;
      ioaddr = ADDR_DATA;
      if (run_q) begin
         case (state_q)
            S_CFG_LO: begin
               iocs   = 1'b1;
               iorw   = 1'b0;
               ioaddr = ADDR_DIV_LO;
            end
            S_CFG_HI: begin
               iocs   = 1'b1;
               iorw   = 1'b0;
               ioaddr = ADDR_DIV_HI;
            end
            S_RD: begin
               iocs   = 1'b1;
               iorw   = 1'b1;
               ioaddr = ADDR_DATA;
            end
            S_WR: begin
               iocs   = 1'b1;
               iorw   = 1'b0;
               ioaddr = ADDR_DATA;
            end
            default: begin
               iocs   = 1'b0;
               iorw   = 1'b1;
               ioaddr = ADDR_DATA;
            end
         endcase
      end
   end

   // Write data for the current access: divisor bytes or the FIFO head.
   always_comb begin
      dout = 8'h00;
      case (state_q)
         S_CFG_LO: dout = div_sel[7:0];
         S_CFG_HI: dout = div_sel[15:8];
         S_WR:     dout = fifo_head;
         default:  dout = 8'h00;
      endcase
   end

   assign bus_drive = iocs && !iorw;
   assign databus   = bus_drive ? dout : 8'hzz;
   assign cfg_done  = cfg_done_q;

endmodule

// File: tb/tb_spart_echo_ctrl.sv
module tb_spart_echo_ctrl;

   localparam int CLK_HZ = 50000000;
   localparam int DEPTH  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] br_cfg = 2'b01;
   logic       rda = 1'b0;
   logic       tbr = 1'b0;
   wire        iocs;
   wire        iorw;
   wire  [1:0] ioaddr;
   wire  [7:0] databus;
   wire        cfg_done;
   wire  [2:0] fifo_level;

   logic [7:0] rx_head = 8'h00;
   logic       probe_en = 1'b0;
   logic [7:0] probe_val = 8'h00;

   // spart model drives read data; probe_en lets the bench test that the bus is released.
   assign databus = (iocs && iorw) ? rx_head : (probe_en ? probe_val : 8'hzz);

   spart_echo_ctrl #(.CLK_HZ(CLK_HZ), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .br_cfg     (br_cfg),
      .rda        (rda),
      .tbr        (tbr),
      .iocs       (iocs),
      .iorw       (iorw),
      .ioaddr     (ioaddr),
      .databus    (databus),
      .cfg_done   (cfg_done),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] tx_log[$];
   int         acc_q[$];   // 0 = read access, 1 = write access
   int         model_cnt = 0;
   int         rd_cnt = 0;
   int         tx_cnt = 0;
   bit         rda_en = 0;
   bit         tbr_en = 0;
   bit         pend_rd = 0;
   bit         prev_iocs = 0;
   logic [1:0] prev_addr = 2'b00;
   bit         prev_hi = 0;
   bit         wr_now = 0;
   int         lo_seen = 0;
   int         hi_seen = 0;
   logic [7:0] last_lo = 8'h00;
   logic [7:0] last_hi = 8'h00;
   logic       lo_cfg_done = 1'b0;
   logic [7:0] last_tx = 8'h00;

   function automatic logic [15:0] div_of(input logic [1:0] s);
      int baud;
      baud = 4800 << s;
      return 16'((CLK_HZ / (16 * baud)) - 1);
   endfunction

   function automatic logic [7:0] exp_of(input logic [7:0] b);
`ifdef CASE_FLIP_EN
      if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A)) return b ^ 8'h20;
`endif
      return b;
   endfunction

   task automatic clear_model();
      exp_q.delete();
      model_cnt = 0;
      pend_rd   = 0;
      prev_iocs = 0;
      prev_addr = 2'b00;
      prev_hi   = 0;
   endtask

   // One clock: update spart model after the edge, then observe the bus mid-cycle.
   task automatic cycle();
      logic [15:0] d;
      logic [7:0]  e;
      @(posedge clk);
      #1;
      if (pend_rd) begin
         void'(rx_q.pop_front());
         pend_rd = 0;
      end
      rda     = rda_en && (rx_q.size() > 0);
      rx_head = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      tbr     = tbr_en;
      @(negedge clk);
      wr_now = 0;
      if (rst) begin
         d = div_of(br_cfg);
         n_checks++;
         if (fifo_level !== 3'(model_cnt)) begin
            n_fail++;
            $display("FAIL fifo_level: got %0d want %0d", fifo_level, model_cnt);
         end
         if (prev_hi) begin
            n_checks++;
            if (cfg_done !== 1'b1) begin
               n_fail++;
               $display("FAIL cfg_done_after_hi: got %b want 1", cfg_done);
            end
         end
         if (iocs) begin
            n_checks++;
            if (prev_iocs && !(prev_addr == 2'b10 && ioaddr == 2'b11)) begin
               n_fail++;
               $display("FAIL access_spacing: addr %b follows addr %b", ioaddr, prev_addr);
            end
            if (ioaddr == 2'b10) begin
               n_checks++;
               lo_seen++;
               last_lo     = databus;
               lo_cfg_done = cfg_done;
               if (iorw !== 1'b0 || databus !== d[7:0]) begin
                  n_fail++;
                  $display("FAIL div_lo: rw %b data %h want rw 0 data %h", iorw, databus, d[7:0]);
               end
            end else if (ioaddr == 2'b11) begin
               n_checks++;
               hi_seen++;
               last_hi = databus;
               if (iorw !== 1'b0 || databus !== d[15:8] || !(prev_iocs && prev_addr == 2'b10)) begin
                  n_fail++;
                  $display("FAIL div_hi: rw %b data %h want rw 0 data %h after lo", iorw, databus, d[15:8]);
               end
            end else if (ioaddr == 2'b00 && iorw) begin
               n_checks++;
               if (model_cnt >= DEPTH || rx_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL rd_legal: level %0d rx pending %0d", model_cnt, rx_q.size());
               end else begin
                  exp_q.push_back(exp_of(databus));
                  pend_rd = 1;
                  model_cnt++;
                  rd_cnt++;
                  acc_q.push_back(0);
               end
            end else if (ioaddr == 2'b00) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL wr_legal: write %h with empty model fifo", databus);
               end else begin
                  e = exp_q.pop_front();
                  if (databus !== e) begin
                     n_fail++;
                     $display("FAIL echo_data: got %h want %h", databus, e);
                  end
                  model_cnt--;
               end
               tx_cnt++;
               last_tx = databus;
               tx_log.push_back(databus);
               acc_q.push_back(1);
               wr_now = 1;
            end else begin
               n_checks++;
               n_fail++;
               $display("FAIL status_addr: unexpected access to addr %b", ioaddr);
            end
         end
         prev_hi   = iocs && (ioaddr == 2'b11);
         prev_iocs = iocs;
         prev_addr = ioaddr;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      br_cfg = 2'b01;
      probe_val = 8'h5A;
      probe_en = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (iocs !== 1'b0 || iorw !== 1'b1 || ioaddr !== 2'b00 || cfg_done !== 1'b0 ||
          fifo_level !== 3'd0 || databus !== 8'h5A) begin
         n_fail++;
         $display("FAIL reset_state: iocs %b iorw %b addr %b done %b lvl %0d bus %h want 0 1 00 0 0 5a",
                  iocs, iorw, ioaddr, cfg_done, fifo_level, databus);
      end
      probe_en = 1'b0;
      clear_model();
      rst = 1'b1;
      for (int i = 0; i < 10 && lo_seen == 0; i++) cycle();
      n_checks++;
      if (lo_seen != 1 || last_lo !== 8'h44 || lo_cfg_done !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_lo_9600: seen %0d data %h done %b want 1 44 0", lo_seen, last_lo, lo_cfg_done);
      end
      cycle();
      n_checks++;
      if (hi_seen != 1 || last_hi !== 8'h01) begin
         n_fail++;
         $display("FAIL cfg_hi_9600: seen %0d data %h want 1 01", hi_seen, last_hi);
      end
      cycle();
      n_checks++;
      if (cfg_done !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg_done_set: got %b want 1", cfg_done);
      end
   endtask

   task automatic test_echo();
      int t0, maxl;
      logic [7:0] want;
      t0 = tx_cnt;
      maxl = 0;
      rx_q.push_back(8'h41);
      rda_en = 1;
      tbr_en = 1;
      for (int i = 0; i < 30 && tx_cnt == t0; i++) begin
         cycle();
         if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
      end
      cycle();
      want = exp_of(8'h41);
      n_checks++;
      if (tx_cnt != t0 + 1 || last_tx !== want || maxl != 1 || fifo_level !== 3'd0) begin
         n_fail++;
         $display("FAIL echo_single: tx %0d data %h peak %0d lvl %0d want 1 %h 1 0",
                  tx_cnt - t0, last_tx, maxl, fifo_level, want);
      end
   endtask

   task automatic test_full();
      logic [7:0] b[5];
      int r0, t0;
      tbr_en = 0;
      rda_en = 1;
      r0 = rd_cnt;
      for (int i = 0; i < 5; i++) begin
         b[i] = 8'($urandom);
         rx_q.push_back(b[i]);
      end
      repeat (40) cycle();
      n_checks++;
      if (fifo_level !== 3'd4 || rd_cnt - r0 != 4 || rx_q.size() != 1 || rda !== 1'b1) begin
         n_fail++;
         $display("FAIL fifo_saturate: lvl %0d reads %0d pending %0d rda %b want 4 4 1 1",
                  fifo_level, rd_cnt - r0, rx_q.size(), rda);
      end
      t0 = tx_log.size();
      tbr_en = 1;
      for (int i = 0; i < 150 && tx_log.size() < t0 + 5; i++) cycle();
      n_checks++;
      if (tx_log.size() != t0 + 5) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d bytes want 5", tx_log.size() - t0);
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (tx_log[t0 + i] !== exp_of(b[i])) begin
               n_fail++;
               $display("FAIL drain_order[%0d]: got %h want %h", i, tx_log[t0 + i], exp_of(b[i]));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int r0;
      tbr_en = 0;
      rda_en = 1;
      r0 = rd_cnt;
      for (int i = 0; i < 10; i++) rx_q.push_back(8'($urandom));
      for (int i = 0; i < 30 && rd_cnt - r0 < 2; i++) cycle();
      rda_en = 0;
      repeat (3) cycle();
      n_checks++;
      if (fifo_level !== 3'd2) begin
         n_fail++;
         $display("FAIL prefill_two: got %0d want 2", fifo_level);
      end
      acc_q.delete();
      rda_en = 1;
      tbr_en = 1;
      for (int i = 0; i < 100 && acc_q.size() < 8; i++) cycle();
      n_checks++;
      if (acc_q.size() < 8) begin
         n_fail++;
         $display("FAIL alternate_timeout: got %0d accesses want 8", acc_q.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (acc_q[i] != ((i % 2 == 0) ? 1 : 0)) begin
               n_fail++;
               $display("FAIL round_robin[%0d]: got %0d want %0d (1=wr 0=rd)", i, acc_q[i], (i % 2 == 0) ? 1 : 0);
            end
         end
      end
      for (int i = 0; i < 200 && (rx_q.size() > 0 || model_cnt > 0); i++) cycle();
   endtask

   task automatic test_cfg_change();
      int h0, t0;
      logic [7:0] b0, b1;
      tbr_en = 0;
      rda_en = 1;
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      rx_q.push_back(b0);
      rx_q.push_back(b1);
      for (int i = 0; i < 40 && model_cnt < 2; i++) cycle();
      rda_en = 0;
      repeat (3) cycle();
      h0 = hi_seen;
      br_cfg = 2'b11;
      for (int i = 0; i < 20 && hi_seen == h0; i++) cycle();
      n_checks++;
      if (hi_seen != h0 + 1 || last_lo !== 8'h50 || last_hi !== 8'h00 || lo_cfg_done !== 1'b0 ||
          fifo_level !== 3'd2) begin
         n_fail++;
         $display("FAIL reprogram_38400: lo %h hi %h done %b lvl %0d want 50 00 0 2",
                  last_lo, last_hi, lo_cfg_done, fifo_level);
      end
      cycle();
      n_checks++;
      if (cfg_done !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg_done_reprog: got %b want 1", cfg_done);
      end
      t0 = tx_log.size();
      tbr_en = 1;
      for (int i = 0; i < 60 && model_cnt > 0; i++) cycle();
      n_checks++;
      if (tx_log.size() != t0 + 2 || tx_log[t0] !== exp_of(b0) || tx_log[t0 + 1] !== exp_of(b1)) begin
         n_fail++;
         $display("FAIL preserved_fifo: got %0d bytes, want %h %h", tx_log.size() - t0, exp_of(b0), exp_of(b1));
      end
   endtask

   task automatic test_reset_mid_wr();
      int l0;
      bit seen;
      seen = 0;
      rx_q.push_back(8'($urandom));
      rda_en = 1;
      tbr_en = 1;
      for (int i = 0; i < 30 && !seen; i++) begin
         cycle();
         seen = wr_now;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL wr_timeout: no write access seen");
      end
      probe_val = ~last_tx;
      probe_en = 1'b1;
      rst = 1'b0;
      #1;
      n_checks++;
      if (iocs !== 1'b0 || databus !== probe_val) begin
         n_fail++;
         $display("FAIL reset_mid_wr: iocs %b bus %h want 0 %h (released)", iocs, databus, probe_val);
      end
      probe_en = 1'b0;
      clear_model();
      @(negedge clk);
      rst = 1'b1;
      l0 = lo_seen;
      cycle();
      n_checks++;
      if (fifo_level !== 3'd0) begin
         n_fail++;
         $display("FAIL level_after_reset: got %0d want 0", fifo_level);
      end
      for (int i = 0; i < 10 && lo_seen == l0; i++) cycle();
      n_checks++;
      if (lo_seen != l0 + 1 || last_lo !== 8'h50) begin
         n_fail++;
         $display("FAIL cfg_reissue: seen %0d data %h want 1 50", lo_seen - l0, last_lo);
      end
      repeat (3) cycle();
   endtask

   task automatic test_random();
      int since;
      since = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0 && rx_q.size() < 8) rx_q.push_back(8'($urandom));
         rda_en = ($urandom_range(0, 4) != 0);
         tbr_en = ($urandom_range(0, 2) != 0);
         since++;
         if (since > 30 && $urandom_range(0, 40) == 0) begin
            br_cfg = 2'($urandom);
            since = 0;
         end
         cycle();
      end
      rda_en = 1;
      tbr_en = 1;
      for (int i = 0; i < 300 && (rx_q.size() > 0 || model_cnt > 0); i++) cycle();
      repeat (3) cycle();
      n_checks++;
      if (exp_q.size() != 0 || rx_q.size() != 0 || fifo_level !== 3'd0) begin
         n_fail++;
         $display("FAIL random_drain: model %0d pending %0d lvl %0d want 0 0 0",
                  exp_q.size(), rx_q.size(), fifo_level);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_echo();
      test_full();
      test_back_to_back();
      test_cfg_change();
      test_reset_mid_wr();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
